// File: rtl/barrier_array.sv
// Multi-slot hardware barrier: per-slot participant count, arrival mask and
// wrapping generation counter, with a registered one-cycle release per slot.
module barrier_array #(
  parameter int N_BARRIERS     = 4,
  parameter int N_PARTICIPANTS = 32,
  parameter int GEN_WIDTH      = 8,
  localparam int BW = (N_BARRIERS > 1) ? $clog2(N_BARRIERS) : 1,
  localparam int IW = $clog2(N_PARTICIPANTS),
  localparam int CW = $clog2(N_PARTICIPANTS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_cfg_valid,
  input  logic [BW-1:0]                     i_cfg_bar,
  input  logic [CW-1:0]                     i_cfg_count,
  input  logic                              i_arrive,
  input  logic [BW-1:0]                     i_arrive_bar,
  input  logic [IW-1:0]                     i_arrive_id,
  output logic [N_BARRIERS-1:0]             o_release,
  output logic [N_BARRIERS*GEN_WIDTH-1:0]   o_gen_out,
  output logic [N_BARRIERS-1:0]             o_pending,
  output logic                              o_err_dup,
  output logic                              o_err_range,
  output logic                              o_err_cfg
);

  logic [CW-1:0]             r_expected [N_BARRIERS];
  logic [N_PARTICIPANTS-1:0] r_mask     [N_BARRIERS];
  logic [CW-1:0]             r_count    [N_BARRIERS];
  logic [GEN_WIDTH-1:0]      r_gen      [N_BARRIERS];
  logic [N_BARRIERS-1:0]     r_release;
  logic                      r_err_dup;
  logic                      r_err_range;
  logic                      r_err_cfg;

  logic w_arr_in;
  logic w_dup;
  logic w_complete;
  logic w_cfg_ok;

  always_comb begin
    w_arr_in   = i_arrive
                 && (32'(i_arrive_bar) < 32'(N_BARRIERS))
                 && (32'(i_arrive_id) < 32'(N_PARTICIPANTS));
    w_dup      = 1'b0;
    w_complete = 1'b0;
    if (w_arr_in) begin
      w_dup      = r_mask[i_arrive_bar][i_arrive_id];
      w_complete = !w_dup && (({1'b0, r_count[i_arrive_bar]} + 1'b1)
                              == {1'b0, r_expected[i_arrive_bar]});
    end
    // Reconfiguring only an idle slot keeps count < expected at all times.
    w_cfg_ok = i_cfg_valid
               && (32'(i_cfg_bar) < 32'(N_BARRIERS))
               && (32'(i_cfg_count) >= 32'd1)
               && (32'(i_cfg_count) <= 32'(N_PARTICIPANTS))
               && (r_count[i_cfg_bar] == '0)
               && !(w_arr_in && (i_arrive_bar == i_cfg_bar));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_BARRIERS; k++) begin
        r_expected[k] <= CW'(N_PARTICIPANTS);
        r_mask[k]     <= '0;
        r_count[k]    <= '0;
        r_gen[k]      <= '0;
      end
      r_release   <= '0;
      r_err_dup   <= 1'b0;
      r_err_range <= 1'b0;
      r_err_cfg   <= 1'b0;
    end else begin
      r_release   <= '0;
      r_err_dup   <= w_dup;
      r_err_range <= i_arrive && !w_arr_in;
      r_err_cfg   <= i_cfg_valid && !w_cfg_ok;
      for (int k = 0; k < N_BARRIERS; k++) begin
        if (w_arr_in && !w_dup && (i_arrive_bar == BW'(k))) begin
          if (w_complete) begin
            r_mask[k]    <= '0;
            r_count[k]   <= '0;
            r_gen[k]     <= r_gen[k] + 1'b1;
            r_release[k] <= 1'b1;
          end else begin
            r_mask[k][i_arrive_id] <= 1'b1;
            r_count[k]             <= r_count[k] + 1'b1;
          end
        end
        if (w_cfg_ok && (i_cfg_bar == BW'(k))) begin
          r_expected[k] <= i_cfg_count;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BARRIERS; gi++) begin : g_slot
      assign o_gen_out[gi*GEN_WIDTH +: GEN_WIDTH] = r_gen[gi];
      assign o_pending[gi]                        = |r_count[gi];
    end
  endgenerate

  assign o_release   = r_release;
  assign o_err_dup   = r_err_dup;
  assign o_err_range = r_err_range;
  assign o_err_cfg   = r_err_cfg;

endmodule

// File: tb/tb_barrier_array.sv
// Bench for barrier_array: directed scenarios plus random traffic, every cycle
// compared against a set/popcount reference model of the barrier slots.
module tb_barrier_array;
  localparam int NB = 4;
  localparam int NP = 32;
  localparam int GW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            cfg_valid;
  logic [1:0]      cfg_bar;
  logic [5:0]      cfg_count;
  logic            arrive;
  logic [1:0]      arrive_bar;
  logic [4:0]      arrive_id;
  logic [NB-1:0]   o_release;
  logic [NB*GW-1:0] o_gen_out;
  logic [NB-1:0]   o_pending;
  logic            o_err_dup;
  logic            o_err_range;
  logic            o_err_cfg;

  barrier_array #(.N_BARRIERS(NB), .N_PARTICIPANTS(NP), .GEN_WIDTH(GW)) dut (
    .clk(clk), .rst(rst),
    .i_cfg_valid(cfg_valid), .i_cfg_bar(cfg_bar), .i_cfg_count(cfg_count),
    .i_arrive(arrive), .i_arrive_bar(arrive_bar), .i_arrive_id(arrive_id),
    .o_release(o_release), .o_gen_out(o_gen_out), .o_pending(o_pending),
    .o_err_dup(o_err_dup), .o_err_range(o_err_range), .o_err_cfg(o_err_cfg)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: each slot is a set of arrived ids plus a target size.
  int          m_exp [NB];
  bit [NP-1:0] m_arr [NB];
  int          m_gen [NB];
  bit [NB-1:0] m_rel;
  bit          m_dup, m_rng, m_cfg;

  function automatic void model_step();
    int  ab, ai, cb, cc, new_exp;
    bit  arr_in, cfg_ok;
    m_rel = '0; m_dup = 0; m_rng = 0; m_cfg = 0;
    if (rst) begin
      for (int k = 0; k < NB; k++) begin
        m_exp[k] = NP; m_arr[k] = '0; m_gen[k] = 0;
      end
      return;
    end
    ab = int'(arrive_bar); ai = int'(arrive_id);
    cb = int'(cfg_bar);    cc = int'(cfg_count);
    arr_in = arrive && (ab < NB) && (ai < NP);
    if (arrive && !arr_in) m_rng = 1;
    cfg_ok = 0; new_exp = 0;
    if (cfg_valid) begin
      cfg_ok = (cb < NB) && (cc >= 1) && (cc <= NP) && !(arr_in && ab == cb);
      if (cfg_ok && m_arr[cb] != '0) cfg_ok = 0;
      if (cfg_ok) new_exp = cc;
      else m_cfg = 1;
    end
    if (arr_in) begin
      if (m_arr[ab][ai]) m_dup = 1;
      else if ($countones(m_arr[ab]) + 1 == m_exp[ab]) begin
        m_arr[ab] = '0;
        m_gen[ab] = (m_gen[ab] + 1) % (1 << GW);
        m_rel[ab] = 1;
      end else m_arr[ab][ai] = 1;
    end
    if (cfg_ok) m_exp[cb] = new_exp;
  endfunction

  task automatic check_model(string tag);
    logic [NB*GW-1:0] eg;
    logic [NB-1:0]    ep;
    for (int k = 0; k < NB; k++) begin
      eg[k*GW +: GW] = GW'(m_gen[k]);
      ep[k]          = (m_arr[k] != '0);
    end
    checks++;
    assert (o_release === m_rel) else begin
      failures++; $error("FAIL %s release got=%b exp=%b", tag, o_release, m_rel);
    end
    checks++;
    assert (o_gen_out === eg) else begin
      failures++; $error("FAIL %s gen_out got=%h exp=%h", tag, o_gen_out, eg);
    end
    checks++;
    assert (o_pending === ep) else begin
      failures++; $error("FAIL %s pending got=%b exp=%b", tag, o_pending, ep);
    end
    checks++;
    assert ({o_err_dup, o_err_range, o_err_cfg} === {m_dup, m_rng, m_cfg}) else begin
      failures++;
      $error("FAIL %s errs(dup,range,cfg) got=%b%b%b exp=%b%b%b", tag,
             o_err_dup, o_err_range, o_err_cfg, m_dup, m_rng, m_cfg);
    end
  endtask

  task automatic chk(string tag, int got, int expv);
    checks++;
    assert (got === expv) else begin
      failures++; $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  task automatic cyc(string tag, bit r, bit cv, int cb, int cc, bit av, int abar, int aid);
    rst = r; cfg_valid = cv; cfg_bar = 2'(cb); cfg_count = 6'(cc);
    arrive = av; arrive_bar = 2'(abar); arrive_id = 5'(aid);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle(string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int rel_seen;

  initial begin
    rst = 1; cfg_valid = 0; cfg_bar = 0; cfg_count = 0;
    arrive = 0; arrive_bar = 0; arrive_id = 0;
    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    chk("reset_outputs", int'({o_release, o_pending, o_err_dup, o_err_range, o_err_cfg}), 0);
    chk("reset_gen", int'(o_gen_out), 0);

    // Slot 0 at default size: 32 arrivals release exactly once.
    rel_seen = 0;
    for (int i = 0; i < NP; i++) begin
      cyc("t1_arrive", 0, 0, 0, 0, 1, 0, i);
      rel_seen += int'(o_release[0]);
    end
    chk("t1_release_after_id31", int'(o_release[0]), 1);
    idle("t1_idle");
    rel_seen += int'(o_release[0]);
    chk("t1_release_once", rel_seen, 1);
    chk("t1_gen0", int'(o_gen_out[0 +: GW]), 1);
    chk("t1_pending0", int'(o_pending[0]), 0);

    // Slot 2 sized 3 with a duplicate arrival.
    cyc("t2_cfg", 0, 1, 2, 3, 0, 0, 0);
    chk("t2_cfg_ok", int'(o_err_cfg), 0);
    cyc("t2_a5", 0, 0, 0, 0, 1, 2, 5);
    cyc("t2_a5dup", 0, 0, 0, 0, 1, 2, 5);
    chk("t2_err_dup", int'(o_err_dup), 1);
    cyc("t2_a7", 0, 0, 0, 0, 1, 2, 7);
    chk("t2_no_dup", int'(o_err_dup), 0);
    cyc("t2_a9", 0, 0, 0, 0, 1, 2, 9);
    chk("t2_release2", int'(o_release[2]), 1);
    chk("t2_gen2", int'(o_gen_out[2*GW +: GW]), 1);

    // Slots 1 and 3 sized 2, interleaved.
    cyc("t3_cfg1", 0, 1, 1, 2, 0, 0, 0);
    cyc("t3_cfg3", 0, 1, 3, 2, 0, 0, 0);
    cyc("t3_a1", 0, 0, 0, 0, 1, 1, 4);
    cyc("t3_a3", 0, 0, 0, 0, 1, 3, 4);
    cyc("t3_b1", 0, 0, 0, 0, 1, 1, 6);
    chk("t3_release1", int'(o_release), 4'b0010);
    chk("t3_pending3", int'(o_pending[3]), 1);
    cyc("t3_b3", 0, 0, 0, 0, 1, 3, 8);
    chk("t3_release3", int'(o_release), 4'b1000);

    // Rejected configurations leave slot 1 sized 2.
    cyc("t4_a1", 0, 0, 0, 0, 1, 1, 0);
    cyc("t4_cfg_busy", 0, 1, 1, 3, 0, 0, 0);
    chk("t4_err_busy", int'(o_err_cfg), 1);
    cyc("t4_cfg_zero", 0, 1, 1, 0, 0, 0, 0);
    chk("t4_err_zero", int'(o_err_cfg), 1);
    cyc("t4_cfg_33", 0, 1, 1, 33, 0, 0, 0);
    chk("t4_err_33", int'(o_err_cfg), 1);
    cyc("t4_b1", 0, 0, 0, 0, 1, 1, 1);
    chk("t4_release1", int'(o_release[1]), 1);

    // Size 1: 256 back-to-back releases wrap gen to 0.
    cyc("t5_rst", 1, 0, 0, 0, 0, 0, 0);
    cyc("t5_cfg", 0, 1, 0, 1, 0, 0, 0);
    rel_seen = 0;
    for (int i = 0; i < 256; i++) begin
      cyc("t5_arrive", 0, 0, 0, 0, 1, 0, int'($urandom_range(0, NP - 1)));
      rel_seen += int'(o_release[0]);
    end
    chk("t5_release_count", rel_seen, 256);
    chk("t5_gen_wrap", int'(o_gen_out[0 +: GW]), 0);
    idle("t5_idle");

    // Reset mid-barrier, then a clean 32-participant round.
    cyc("t6_rst", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("t6_partial", 0, 0, 0, 0, 1, 0, i);
    chk("t6_pending", int'(o_pending[0]), 1);
    cyc("t6_midrst", 1, 0, 0, 0, 1, 0, 20);
    chk("t6_outputs_zero", int'({o_release, o_pending, o_err_dup, o_err_range, o_err_cfg}), 0);
    for (int i = 0; i < NP; i++) cyc("t6_full", 0, 0, 0, 0, 1, 0, NP - 1 - i);
    chk("t6_release", int'(o_release[0]), 1);
    chk("t6_gen", int'(o_gen_out[0 +: GW]), 1);

    // Random traffic with small id range to exercise duplicates and completions.
    for (int i = 0; i < 800; i++) begin
      cyc("rand",
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 5) == 0), int'($urandom_range(0, NB - 1)),
          int'($urandom_range(0, 34)),
          ($urandom_range(0, 3) != 0), int'($urandom_range(0, NB - 1)),
          int'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
